// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor, LSB first; optional ovf output under SERIAL_SUB_OVF_EN
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a_bit, b_bit, d_bit, brw_next;

  // Single-bit borrow cell for the bit currently selected by the counter
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    d_bit    = a_bit ^ b_bit ^ brw_q;
    brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
  end

  // Next-state logic: accept start only outside RUN, resolve one bit per cycle in RUN
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          d_d     = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        d_d[cnt_q] = d_bit;
        brw_d      = brw_next;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = brw_next;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_bit);
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset clears everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [3:0] d;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; lat counts cycles from the start edge
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       output int lat, output int busy_cycles, output int overlap);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; busy_cycles = 0; overlap = 0;
    while (done !== 1'b1 && lat < 12) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      lat++;
    end
    if (busy === 1'b1) overlap = 1;
  endtask

  initial begin
    int lat, bc, ov;
    logic [4:0] diff;
    logic seen_done;

    rst_n = 1'b0; start = 1'b1; a = 4'hF; b = 4'hF; bin = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    rst_n = 1'b1; start = 1'b0;
    tick();

    // 5 - 3 - 0
    do_op(4'b0101, 4'b0011, 1'b0, lat, bc, ov);
    check("t1_latency", lat, 5);
    check("t1_busy_cycles", bc, 4);
    check("t1_overlap", ov, 0);
    check("t1_d", d, 4'b0010);
    check("t1_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("t1_ovf", ovf, 0);
`endif
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_hold_d", d, 4'b0010);
    tick();
    check("t1_idle_busy", busy, 0);

    // 3 - 5 - 0
    do_op(4'b0011, 4'b0101, 1'b0, lat, bc, ov);
    check("t2_d", d, 4'b1110);
    check("t2_bout", bout, 1);
    tick();

    // 0 - 0 - 1
    do_op(4'b0000, 4'b0000, 1'b1, lat, bc, ov);
    check("t3_d", d, 4'b1111);
    check("t3_bout", bout, 1);
    tick();

    // 8 - 7 - 1
    do_op(4'b1000, 4'b0111, 1'b1, lat, bc, ov);
    check("t4_d", d, 4'b0000);
    check("t4_bout", bout, 0);
    tick();

`ifdef SERIAL_SUB_OVF_EN
    do_op(4'b1000, 4'b0001, 1'b0, lat, bc, ov);
    check("ovf_d", d, 4'b0111);
    check("ovf_flag", ovf, 1);
    check("ovf_bout", bout, 0);
    tick();
`endif

    // start pulses and operand changes during RUN cycles 1-3 are ignored
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    tick();
    a = 4'hF; b = 4'h1; bin = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check("ign_latency", lat, 5);
    check("ign_d", d, 4'b0010);
    check("ign_bout", bout, 0);
    tick();

    // back-to-back: start presented in the DONE cycle
    do_op(4'b0011, 4'b0101, 1'b0, lat, bc, ov);
    check("b2b_first_d", d, 4'b1110);
    a = 4'b0000; b = 4'b0000; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check("b2b_gap", lat, 5);
    check("b2b_second_d", d, 4'b1111);
    check("b2b_second_bout", bout, 1);

    // reset while resolving bit 2
    a = 4'b0000; b = 4'b0000; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_d", d, 0);
    check("mrst_bout", bout, 0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("mrst_no_done", seen_done, 0);
    do_op(4'b0101, 4'b0011, 1'b0, lat, bc, ov);
    check("mrst_restart_latency", lat, 5);
    check("mrst_restart_d", d, 4'b0010);
    tick();

    // exhaustive sweep against unsigned arithmetic
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      diff = {1'b0, v[3:0]} - {1'b0, v[7:4]} - {4'b0, v[8]};
      do_op(v[3:0], v[7:4], v[8], lat, bc, ov);
      check($sformatf("ex_d a=%0h b=%0h bin=%0b", v[3:0], v[7:4], v[8]), d, diff[3:0]);
      check($sformatf("ex_bout a=%0h b=%0h bin=%0b", v[3:0], v[7:4], v[8]), bout, diff[4]);
      if (lat != 5) check("ex_latency", lat, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits, legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 SHALL have port bin  input  1  borrow-in; captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-010 SHALL have port d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; high when a < b + bin, unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL transition IDLE->RUN on an edge with start=1; that edge latches a, b and bin, clears the bit counter and clears d.
REQ-014 SHALL, in RUN, resolve one bit per edge, LSB first: d[i] = a[i]^b[i]^brw; brw_next = (~a[i]&b[i]) | (~(a[i]^b[i])&brw); brw initialised from bin.
REQ-015 SHALL transition RUN->DONE on the edge that resolves bit WIDTH-1, and load bout from the final borrow on that same edge.
REQ-016 SHALL assert done exactly in the cycle after that edge, i.e. WIDTH+1 edges after the start edge.
REQ-017 SHALL transition DONE->RUN if start=1 on the next edge (back-to-back, no idle cycle); otherwise DONE->IDLE.
REQ-018 SHALL hold d and bout stable from done until the next accepted start.
REQ-019 SHALL ignore start while busy=1; operands and progress are unaffected.
REQ-020 SHALL drive busy=1 only in RUN and done=1 only in DONE; both SHALL never be high together.
REQ-021 SHALL only change a, b and bin internally at an accepted start; input changes during RUN have no effect.
REQ-022 SHALL count bits with a counter of width ceil(log2(WIDTH)) that never wraps past WIDTH-1.

Reset
REQ-023 SHALL, on any edge with rst_n=0, force IDLE and clear busy, done, d, bout, the counter and the internal borrow, regardless of start.
REQ-024 SHALL, if reset occurs mid-RUN, abort the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-025 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add output port ovf (1 bit): two's-complement overflow = (a[W-1]^b[W-1]) & (a[W-1]^d[W-1]), loaded with bout, held and reset like bout.
REQ-026 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port and no ovf logic, with all other behaviour identical.

Verification
REQ-027 SHALL check: a=0101, b=0011, bin=0, start -> done 5 cycles later, d=0010, bout=0, busy high 4 cycles.
REQ-028 SHALL check: a=0011, b=0101, bin=0 -> d=1110, bout=1; a=0000, b=0000, bin=1 -> d=1111, bout=1.
REQ-029 SHALL check: a=1000, b=0111, bin=1 -> d=0000, bout=0; with SERIAL_SUB_OVF_EN, a=1000, b=0001, bin=0 -> d=0111, ovf=1.
REQ-030 SHALL check: start pulses and operand changes at cycles 1-3 of RUN are ignored; back-to-back start in DONE -> second done exactly 5 cycles after the first.
REQ-031 SHALL check: rst_n=0 at RUN bit 2 -> next cycle busy=0, done=0, d=0, bout=0; no done appears until a new start.
REQ-032 SHALL check: all 512 combinations of (a, b, bin) against a - b - bin, for both d and bout.
